fb_pingpong: RTL

- Double-buffered (ping-pong) frame store between the core's pixel writer (hh/vv/RGB332/color_ready/frame) and the video timing generator's raster readout (hcount/vcount).
- The core draws into the back bank while the front bank is scanned out.
- Bank swaps are synchronous to clk_sys and deferred to the start of vertical blank, which gives tear-free output.
- Replaces the ad-hoc VRAM array and edge-clocked bank flip at emu level.

---
 rtl/fb_pingpong.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/fb_pingpong.sv
// fb_pingpong: double-buffered (ping-pong) frame store.
//
// The core draws into the back bank while the video raster scans the front
// bank. A rising edge on `frame` requests a bank swap. The swap is held off
// until the next rising edge of `vblank`, so the picture never tears.
//
// Optional feature macro: FB_AUTOCLEAR_EN. When defined, every executed swap
// starts a sweep that writes zero over the new back bank. Core writes take
// priority over the sweep and stall it.
//
// Ports:
//   clk_sys       in   system clock; everything is on its rising edge
//   reset         in   synchronous active-high reset
//   wr_en         in   pixel write strobe (one write per cycle)
//   wr_x / wr_y   in   write column / row
//   wr_pix        in   write pixel (RGB332)
//   frame         in   frame-done level; a rising edge requests a swap
//   ce_pix        in   pixel clock enable from the video timing
//   vblank        in   vertical blank; a rising edge executes a pending swap
//   rd_de         in   display enable
//   rd_x / rd_y   in   raster column / row (9 bits, from hcount/vcount)
//   pix_out       out  registered pixel to the video output
//   front_bank    out  bank currently being scanned out
//   swap_pending  out  swap requested, not yet executed
//   swap_drop     out  one-cycle pulse: request seen while one was pending
//   clr_busy      out  back-bank clear sweep running (0 without the macro)
module fb_pingpong #(
    parameter int XW = 8,
    parameter int YW = 8,
    parameter int PW = 8
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [XW-1:0] wr_x,
    input  logic [YW-1:0] wr_y,
    input  logic [PW-1:0] wr_pix,
    input  logic          frame,
    input  logic          ce_pix,
    input  logic          vblank,
    input  logic          rd_de,
    input  logic [8:0]    rd_x,
    input  logic [8:0]    rd_y,
    output logic [PW-1:0] pix_out,
    output logic          front_bank,
    output logic          swap_pending,
    output logic          swap_drop,
    output logic          clr_busy
);

    localparam int AW    = XW + YW;
    localparam int DEPTH = 2 ** (AW + 1);

    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

    state_t        state_q;
    logic          front_bank_q;
    logic          swap_pending_q;
    logic          swap_drop_q;
    logic          frame_q;
    logic          vblank_q;

    logic          frame_rise_s;
    logic          vblank_rise_s;
    logic          swap_now_s;

    logic [PW-1:0] mem_q [DEPTH];
    logic          mem_we_s;
    logic [AW:0]   mem_waddr_s;
    logic [PW-1:0] mem_wdata_s;

    logic          rd_in_s;
    logic          rd_load_q;
    logic          rd_ok_q;
    logic [AW:0]   rd_addr_q;
    logic [PW-1:0] pix_out_q;

    logic          clr_busy_s;

    assign frame_rise_s  = frame & ~frame_q;
    assign vblank_rise_s = vblank & ~vblank_q;
    assign swap_now_s    = (state_q == PEND) & vblank_rise_s;

    // Swap request / execution FSM with its registered status outputs.
    // A frame edge and a vblank edge together in IDLE only arm the swap;
    // it executes on the following vblank edge.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q        <= IDLE;
            front_bank_q   <= 1'b0;
            swap_pending_q <= 1'b0;
            swap_drop_q    <= 1'b0;
            frame_q        <= 1'b1;
            vblank_q       <= 1'b1;
        end else begin
            frame_q     <= frame;
            vblank_q    <= vblank;
            swap_drop_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (frame_rise_s) begin
                        state_q        <= PEND;
                        swap_pending_q <= 1'b1;
                    end
                end
                PEND: begin
                    if (vblank_rise_s) begin
                        state_q        <= IDLE;
                        swap_pending_q <= 1'b0;
                        front_bank_q   <= ~front_bank_q;
                    end
                    if (frame_rise_s) begin
                        swap_drop_q <= 1'b1;
                    end
                end
                default: begin
                    state_q        <= IDLE;
                    swap_pending_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef FB_AUTOCLEAR_EN
    logic [AW-1:0] clr_cur_q;
    logic          clr_busy_q;

    // Clear sweep cursor: restarts on every swap and stalls on core writes.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clr_busy_q <= 1'b0;
            clr_cur_q  <= {AW{1'b0}};
        end else if (swap_now_s) begin
            clr_busy_q <= 1'b1;
            clr_cur_q  <= {AW{1'b0}};
        end else if (clr_busy_q && !wr_en) begin
            if (clr_cur_q == {AW{1'b1}}) begin
                clr_busy_q <= 1'b0;
            end else begin
                clr_cur_q <= clr_cur_q + AW'(1);
            end
        end
    end

    // Write-port arbitration: a core write wins; otherwise the sweep writes
    // zero. On the swap cycle the sweep is held so it cannot touch the bank
    // that is becoming front.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = {~front_bank_q, wr_y, wr_x};
        mem_wdata_s = wr_pix;
        if (wr_en) begin
            mem_we_s = 1'b1;
        end else if (clr_busy_q && !swap_now_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = {~front_bank_q, clr_cur_q};
            mem_wdata_s = {PW{1'b0}};
        end else begin
            mem_we_s = 1'b0;
        end
    end

    assign clr_busy_s = clr_busy_q;
`else
    // Write port: only the core writes, always into the back bank.
    always_comb begin
        mem_we_s    = wr_en;
        mem_waddr_s = {~front_bank_q, wr_y, wr_x};
        mem_wdata_s = wr_pix;
    end

    assign clr_busy_s = 1'b0;
`endif

    // Frame store write port. The contents are not reset.
    always_ff @(posedge clk_sys) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Any raster coordinate bit at or above the bank width is off-screen.
    assign rd_in_s = rd_de && ((rd_x >> XW) == 9'd0) && ((rd_y >> YW) == 9'd0);

    // Read stage 1: capture the front-bank address on each pixel enable.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rd_load_q <= 1'b0;
            rd_ok_q   <= 1'b0;
            rd_addr_q <= {(AW + 1){1'b0}};
        end else begin
            rd_load_q <= ce_pix;
            if (ce_pix) begin
                rd_ok_q   <= rd_in_s;
                rd_addr_q <= {front_bank_q, rd_y[YW-1:0], rd_x[XW-1:0]};
            end
        end
    end

    // Read stage 2: present the pixel (or black off-screen) and hold it.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pix_out_q <= {PW{1'b0}};
        end else if (rd_load_q) begin
            pix_out_q <= rd_ok_q ? mem_q[rd_addr_q] : {PW{1'b0}};
        end
    end

    assign pix_out      = pix_out_q;
    assign front_bank   = front_bank_q;
    assign swap_pending = swap_pending_q;
    assign swap_drop    = swap_drop_q;
    assign clr_busy     = clr_busy_s;

endmodule
